// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
// Shared definitions for the weight RAM, the slice packer on its write side and
// the conv-engine reader on its read side.
//   - geometry of the weight RAM (weight width, kernel edge, slice words)
//   - address widths for the slice-wide write port and the per-value read port
//   - packer FSM state encoding
//   - helper mapping (slice, lane) to the reader's flat address
// -----------------------------------------------------------------------------
package weight_pkg;

    localparam int DATA_WIDTH              = 16;
    localparam int KERNEL_SIZE_MAX         = 5;
    localparam int WEIGHT_RAM_MAX          = 27;
    localparam int WEIGHT_WRITE_ADDR_WIDTH = 5;

    // One slice word carries every lane of the largest kernel.
    localparam int LANE_COUNT              = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;

    // The reader addresses single values: slice * LANE_COUNT + lane.
    localparam int WEIGHT_READ_ADDR_WIDTH  = $clog2(WEIGHT_RAM_MAX * LANE_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } packer_state_e;

    function automatic logic [WEIGHT_READ_ADDR_WIDTH-1:0] weight_read_addr(
        input logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slice,
        input logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] lane
    );
        return WEIGHT_READ_ADDR_WIDTH'(slice) * WEIGHT_READ_ADDR_WIDTH'(LANE_COUNT)
             + WEIGHT_READ_ADDR_WIDTH'(lane);
    endfunction

endpackage

// File: rtl/weight_lane_buffer.sv
// -----------------------------------------------------------------------------
// weight_lane_buffer
// Register bank of LANES weights, written one lane at a time and presented as a
// single flat bus (lane i at lanes_flat[i*DATA_WIDTH +: DATA_WIDTH]).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all lanes)
//   clr          synchronous clear of all lanes, wins over wr_en
//   wr_en        write wr_data into lane wr_lane this cycle
//   wr_lane      lane index to write
//   wr_data      weight value
//   lanes_flat   registered packed lanes
// -----------------------------------------------------------------------------
module weight_lane_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 25,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [IDX_WIDTH-1:0]          wr_lane,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [LANES*DATA_WIDTH-1:0]   lanes_flat
);

    logic [LANES*DATA_WIDTH-1:0] lanes_q;
    logic [LANES*DATA_WIDTH-1:0] lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        if (clr) begin
            lanes_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane == IDX_WIDTH'(i)) begin
                    lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign lanes_flat = lanes_q;

endmodule

// File: rtl/weight_slice_packer.sv
// -----------------------------------------------------------------------------
// weight_slice_packer
// Collects a stream of float16 weights into kernel_size^2 lanes of a slice word
// and issues one slice-wide write per slice into the weight RAM.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; rejects an illegal config with an err pulse
//   ST_FILL  | accepting beats into lane k until lane kk-1 is filled
//   ST_WRITE | one cycle of ena_wr with the filled slice on din
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse; latches kernel_size / slice_count
//   kernel_size       kernel edge, legal 1..KERNEL_SIZE_MAX
//   slice_count       slices to load, legal 1..WEIGHT_RAM_MAX
//   s_valid, s_data   weight stream; s_ready accepts a beat
//   ena_wr            RAM write strobe
//   addr_write        slice index of the write
//   din               packed slice word (lane buffer register)
//   busy              load in progress
//   done              one-cycle pulse after the final slice write
//   err               one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module weight_slice_packer #(
    parameter int DATA_WIDTH              = 16,
    parameter int KERNEL_SIZE_MAX         = 5,
    parameter int WEIGHT_RAM_MAX          = 27,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 5
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic [2:0]                                            kernel_size,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]                    slice_count,
    input  logic                                                  s_valid,
    input  logic [DATA_WIDTH-1:0]                                 s_data,
    output logic                                                  s_ready,
    output logic                                                  ena_wr,
    output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]                    addr_write,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] din,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err
);

    import weight_pkg::*;

    localparam int LANES    = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    // Wide enough to hold kk itself (the lane counter reaches kk on the last beat).
    localparam int KK_WIDTH = $clog2(LANES + 1);
    localparam int AW       = WEIGHT_WRITE_ADDR_WIDTH;

    localparam logic [2:0]    KS_MAX = 3'(KERNEL_SIZE_MAX);
    localparam logic [AW-1:0] SC_MAX = AW'(WEIGHT_RAM_MAX);

    packer_state_e         state_q, state_d;
    logic [KK_WIDTH-1:0]   kk_q, kk_d;
    logic [KK_WIDTH-1:0]   lane_idx_q, lane_idx_d;
    logic [AW-1:0]         slice_count_q, slice_count_d;
    logic [AW-1:0]         slice_idx_q, slice_idx_d;
    logic                  s_ready_q, s_ready_d;
    logic                  ena_wr_q, ena_wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  start_ok;
    logic                  beat;
    logic                  last_lane;
    logic                  last_slice;
    logic                  buf_clr;
    logic                  buf_wr;

    always_comb begin
        start_ok = (kernel_size != 3'd0) && (kernel_size <= KS_MAX)
                && (slice_count != '0)   && (slice_count <= SC_MAX);
        beat       = s_valid && s_ready_q;
        last_lane  = (lane_idx_q == (kk_q - KK_WIDTH'(1)));
        last_slice = (slice_idx_q == (slice_count_q - AW'(1)));
    end

    always_comb begin
        state_d       = state_q;
        kk_d          = kk_q;
        lane_idx_d    = lane_idx_q;
        slice_count_d = slice_count_q;
        slice_idx_d   = slice_idx_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        buf_clr       = 1'b0;
        buf_wr        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        kk_d          = KK_WIDTH'(kernel_size) * KK_WIDTH'(kernel_size);
                        slice_count_d = slice_count;
                        slice_idx_d   = '0;
                        lane_idx_d    = '0;
                        buf_clr       = 1'b1;
                        state_d       = ST_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            // start is deliberately not looked at here: a second pulse mid-load
            // must not disturb the slice or lane counters.
            ST_FILL: begin
                if (beat) begin
                    buf_wr     = 1'b1;
                    lane_idx_d = lane_idx_q + KK_WIDTH'(1);
                    if (last_lane) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            // The buffer is cleared on the edge that ends the write cycle, so din
            // holds the slice for the whole ena_wr cycle.
            ST_WRITE: begin
                buf_clr    = 1'b1;
                lane_idx_d = '0;
                if (last_slice) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    slice_idx_d = slice_idx_q + AW'(1);
                    state_d     = ST_FILL;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies decoded from the next state.
        s_ready_d = (state_d == ST_FILL);
        ena_wr_d  = (state_d == ST_WRITE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            kk_q          <= '0;
            lane_idx_q    <= '0;
            slice_count_q <= '0;
            slice_idx_q   <= '0;
            s_ready_q     <= 1'b0;
            ena_wr_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            kk_q          <= kk_d;
            lane_idx_q    <= lane_idx_d;
            slice_count_q <= slice_count_d;
            slice_idx_q   <= slice_idx_d;
            s_ready_q     <= s_ready_d;
            ena_wr_q      <= ena_wr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    weight_lane_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .IDX_WIDTH  (KK_WIDTH)
    ) u_lane_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (buf_clr),
        .wr_en      (buf_wr),
        .wr_lane    (lane_idx_q),
        .wr_data    (s_data),
        .lanes_flat (din)
    );

    // The slice index only advances between slices and stops at slice_count-1,
    // so it doubles as the registered write address.
    assign addr_write = slice_idx_q;
    assign s_ready    = s_ready_q;
    assign ena_wr     = ena_wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_weight_slice_packer.sv
module tb_weight_slice_packer;

    localparam int DW   = 16;
    localparam int DINW = 25 * DW;

    typedef struct {
        logic [4:0]      addr;
        logic [DINW-1:0] din;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [2:0]      kernel_size;
    logic [4:0]      slice_count;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_ready;
    logic            ena_wr;
    logic [4:0]      addr_write;
    logic [DINW-1:0] din;
    logic            busy;
    logic            done;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc, done_cyc, last_wr_cyc, wr_cnt;

    wr_t           sb[$];
    logic [DW-1:0] beats[$];

    weight_slice_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .kernel_size (kernel_size),
        .slice_count (slice_count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ena_wr      (ena_wr),
        .addr_write  (addr_write),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [DINW-1:0] got,
                             input logic [DINW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every RAM write must match the oldest expected slice.
    always @(negedge clk) begin
        if (rst_n && ena_wr) begin
            wr_t e;
            check_val("wr_expected", DINW'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("wr_addr", DINW'(addr_write), DINW'(e.addr));
                check_val("wr_din", din, e.din);
            end
            check_val("wr_s_ready", DINW'(s_ready), 0);
            check_val("wr_busy", DINW'(busy), 1);
            last_wr_cyc = cyc;
            wr_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the sampling edge.
    task automatic pulse_start(input logic [2:0] ks, input logic [4:0] sc);
        kernel_size = ks;
        slice_count = sc;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("beat_timeout", DINW'(ok), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = DW'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check_val("done_seen", DINW'(done), 1);
        check_val("done_busy", DINW'(busy), 0);
        done_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    // Consumes ks*ks*sc values from beats; with mid set, a second start is
    // raised during slice 0 with a different config and must be ignored.
    task automatic run_load(input logic [2:0] ks, input logic [4:0] sc,
                            input int gap, input bit mid);
        int kk;
        logic [DINW-1:0] exp;
        logic [DW-1:0] d;
        kk = int'(ks) * int'(ks);
        pulse_start(ks, sc);
        check_val("start_s_ready", DINW'(s_ready), 1);
        check_val("start_busy", DINW'(busy), 1);
        for (int s = 0; s < int'(sc); s++) begin
            exp = '0;
            for (int k = 0; k < kk; k++) begin
                d = beats.pop_front();
                exp[k*DW +: DW] = d;
                if (k == kk - 1) sb.push_back('{addr: 5'(s), din: exp});
                if (mid && s == 0 && k == 4) begin
                    start       = 1'b1;
                    kernel_size = 3'd5;
                    slice_count = 5'd1;
                end
                send_beat(d, gap);
                start       = 1'b0;
                kernel_size = ks;
                slice_count = sc;
            end
        end
        wait_done();
    endtask

    task automatic load_t1_beats();
        logic [DW-1:0] t[18] = '{16'h3c00, 16'h4000, 16'h4200, 16'h3c00, 16'h4000,
                                 16'h3c00, 16'h0000, 16'h4000, 16'h3c00,
                                 16'h3c00, 16'h4000, 16'h4200, 16'h3c00, 16'h4000,
                                 16'h3c00, 16'h4200, 16'h0000, 16'h3c00};
        beats.delete();
        foreach (t[i]) beats.push_back(t[i]);
    endtask

    initial begin
        int wr0;
        logic [2:0] bad_ks[3] = '{3'd6, 3'd3, 3'd3};
        logic [4:0] bad_sc[3] = '{5'd1, 5'd0, 5'd28};

        rst_n       = 1'b0;
        start       = 1'b0;
        kernel_size = 3'd0;
        slice_count = 5'd0;
        s_valid     = 1'b0;
        s_data      = '0;
        wr_cnt      = 0;
        last_wr_cyc = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check_val("rst_s_ready", DINW'(s_ready), 0);
        check_val("rst_ena_wr", DINW'(ena_wr), 0);
        check_val("rst_addr", DINW'(addr_write), 0);
        check_val("rst_din", din, 0);
        check_val("rst_busy", DINW'(busy), 0);
        check_val("rst_done", DINW'(done), 0);
        check_val("rst_err", DINW'(err), 0);
        @(posedge clk);
        #1;

        // 3x3, two slices, s_valid held high.
        load_t1_beats();
        run_load(3'd3, 5'd2, 0, 1'b0);
        check_val("t1_start_to_done", DINW'(done_cyc - start_cyc), 20);
        check_val("t1_done_after_wr", DINW'(done_cyc - last_wr_cyc), 1);
        check_val("t1_addr_hold", DINW'(addr_write), 1);

        // 5x5, one slice, lane k = k+1.
        beats.delete();
        for (int k = 0; k < 25; k++) beats.push_back(DW'(k + 1));
        run_load(3'd5, 5'd1, 0, 1'b0);
        check_val("t2_start_to_done", DINW'(done_cyc - start_cyc), 26);

        // Same 3x3 data with a gap before every beat, garbage in gaps, and a
        // second start pulse during slice 0.
        load_t1_beats();
        run_load(3'd3, 5'd2, 1, 1'b1);
        check_val("t3_wr_count", DINW'(wr_cnt), 5);

        // Illegal configs.
        wr0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse_start(bad_ks[i], bad_sc[i]);
            check_val("err_pulse", DINW'(err), 1);
            check_val("err_busy", DINW'(busy), 0);
            check_val("err_s_ready", DINW'(s_ready), 0);
            @(posedge clk);
            #1;
            check_val("err_one_cycle", DINW'(err), 0);
            check_val("err_busy_after", DINW'(busy), 0);
        end
        check_val("err_no_write", DINW'(wr_cnt - wr0), 0);

        // Reset after 4 beats of slice 1: partial slice is dropped.
        load_t1_beats();
        pulse_start(3'd3, 5'd2);
        begin
            logic [DINW-1:0] exp;
            exp = '0;
            for (int k = 0; k < 9; k++) begin
                exp[k*DW +: DW] = beats[k];
                if (k == 8) sb.push_back('{addr: 5'd0, din: exp});
                send_beat(beats[k], 0);
            end
            for (int k = 9; k < 13; k++) send_beat(beats[k], 0);
        end
        wr0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        check_val("arst_ena_wr", DINW'(ena_wr), 0);
        check_val("arst_din", din, 0);
        check_val("arst_busy", DINW'(busy), 0);
        check_val("arst_s_ready", DINW'(s_ready), 0);
        check_val("arst_addr", DINW'(addr_write), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("arst_no_write", DINW'(wr_cnt - wr0), 0);
        @(posedge clk);
        #1;
        beats.delete();
        for (int k = 0; k < 9; k++) beats.push_back(DW'(16'h5000 + k));
        run_load(3'd3, 5'd1, 0, 1'b0);
        check_val("arst_new_writes", DINW'(wr_cnt - wr0), 1);

        repeat (3) @(posedge clk);
        check_val("sb_drained", DINW'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
